riscv_proc_divider: RTL and testbench

Iterative 64-bit integer divider for the RISC-V integer pipeline. Accepts one DIV/DIVU/REM/REMU request (64-bit or 32-bit word form) from issue. Computes one quotient bit per cycle and emits a one-cycle result pulse with its destination tag. That pulse enqueues directly into the divider writeback queue of the long-latency writeback stage. Issue logic guarantees queue space, so the result port has no backpressure.

---
 rtl/riscv_proc_divider_pkg.sv | 26 ++
 rtl/riscv_proc_divider.sv | 141 ++++++++++++++
 tb/tb_riscv_proc_divider.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/riscv_proc_divider_pkg.sv
// Shared encodings for the integer divider: operation codes, FSM states
// and small decode helpers.
package riscv_proc_divider_pkg;

    localparam logic [1:0] DIV_FN_DIV  = 2'd0;
    localparam logic [1:0] DIV_FN_DIVU = 2'd1;
    localparam logic [1:0] DIV_FN_REM  = 2'd2;
    localparam logic [1:0] DIV_FN_REMU = 2'd3;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_NEG_IN,
        DIV_BUSY,
        DIV_NEG_OUT,
        DIV_DONE
    } div_state_e;

    function automatic logic fn_is_signed(input logic [1:0] fn);
        return (fn == DIV_FN_DIV) || (fn == DIV_FN_REM);
    endfunction

    function automatic logic fn_is_rem(input logic [1:0] fn);
        return (fn == DIV_FN_REM) || (fn == DIV_FN_REMU);
    endfunction

endpackage

// File: rtl/riscv_proc_divider.sv
// Iterative restoring divider: one quotient bit per cycle, fixed 67-cycle
// latency, one-cycle result pulse with the captured destination tag.
module riscv_proc_divider
    import riscv_proc_divider_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [1:0]       req_fn,
    input  logic             req_dw,
    input  logic [XLEN-1:0]  req_in0,
    input  logic [XLEN-1:0]  req_in1,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             div_result_val,
    output logic [XLEN-1:0]  div_result_bits,
    output logic [TAG_W-1:0] div_result_tag
);

    div_state_e state, state_nxt;

    logic [1:0]       fn;
    logic             dw;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  dividend;
    logic [XLEN-1:0]  divisor;
    logic             neg_quo;
    logic             neg_rem;
    logic             divz;
    logic [6:0]       count;
    logic [2*XLEN-1:0] rq;

    logic             accept;
    logic             req_signed;
    logic [XLEN-1:0]  in0_ext;
    logic [XLEN-1:0]  in1_ext;
    logic [XLEN:0]    step_upper;
    logic [XLEN:0]    step_diff;
    logic             step_fits;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  sel;
    logic [XLEN-1:0]  result_nxt;

    assign req_rdy        = (state == DIV_IDLE);
    assign accept         = req_rdy && req_val && !kill;
    assign div_result_val = (state == DIV_DONE) && !kill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= DIV_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE:    if (accept) state_nxt = DIV_NEG_IN;
            DIV_NEG_IN:  state_nxt = DIV_BUSY;
            DIV_BUSY:    if (count == 7'(XLEN - 1)) state_nxt = DIV_NEG_OUT;
            DIV_NEG_OUT: state_nxt = DIV_DONE;
            DIV_DONE:    state_nxt = DIV_IDLE;
            default:     state_nxt = DIV_IDLE;
        endcase
        if (kill && state != DIV_IDLE) state_nxt = DIV_IDLE;
    end

    // Word ops extend bit 31 for signed forms, zero-extend for unsigned forms.
    always_comb begin
        req_signed = fn_is_signed(req_fn);
        in0_ext    = req_in0;
        in1_ext    = req_in1;
        if (!req_dw) begin
            in0_ext = {{(XLEN-32){req_signed & req_in0[31]}}, req_in0[31:0]};
            in1_ext = {{(XLEN-32){req_signed & req_in1[31]}}, req_in1[31:0]};
        end
    end

    // Restoring step on the remainder with the next dividend bit shifted in;
    // the upper half needs one extra bit before the compare.
    assign step_upper = rq[2*XLEN-1:XLEN-1];
    assign step_diff  = step_upper - {1'b0, divisor};
    assign step_fits  = !step_diff[XLEN];

    always_comb begin
        quo_fix = divz ? '1 : (neg_quo ? -rq[XLEN-1:0] : rq[XLEN-1:0]);
        rem_fix = neg_rem ? -rq[2*XLEN-1:XLEN] : rq[2*XLEN-1:XLEN];
        sel     = fn_is_rem(fn) ? rem_fix : quo_fix;
        result_nxt = dw ? sel : {{(XLEN-32){sel[31]}}, sel[31:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fn              <= '0;
            dw              <= 1'b0;
            tag             <= '0;
            dividend        <= '0;
            divisor         <= '0;
            neg_quo         <= 1'b0;
            neg_rem         <= 1'b0;
            divz            <= 1'b0;
            count           <= '0;
            rq              <= '0;
            div_result_bits <= '0;
            div_result_tag  <= '0;
        end else begin
            case (state)
                DIV_IDLE: if (accept) begin
                    fn       <= req_fn;
                    dw       <= req_dw;
                    tag      <= req_tag;
                    dividend <= in0_ext;
                    divisor  <= in1_ext;
                end
                DIV_NEG_IN: begin
                    neg_quo  <= fn_is_signed(fn) && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                    neg_rem  <= fn_is_signed(fn) && dividend[XLEN-1];
                    divisor  <= (fn_is_signed(fn) && divisor[XLEN-1]) ? -divisor : divisor;
                    divz     <= (divisor == '0);
                    count    <= '0;
                    rq       <= {{XLEN{1'b0}},
                                 (fn_is_signed(fn) && dividend[XLEN-1]) ? -dividend : dividend};
                end
                DIV_BUSY: begin
                    rq    <= {step_fits ? step_diff[XLEN-1:0] : step_upper[XLEN-1:0],
                              rq[XLEN-2:0], step_fits};
                    count <= count + 7'd1;
                end
                DIV_NEG_OUT: if (!kill) begin
                    div_result_bits <= result_nxt;
                    div_result_tag  <= tag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_proc_divider.sv
// Directed-vector bench: the driver queues expected results, a negedge
// monitor pops and compares them whenever the divider pulses a result.
module tb_riscv_proc_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic [1:0]  req_fn = '0;
    logic        req_dw = 1'b1;
    logic [63:0] req_in0 = '0;
    logic [63:0] req_in1 = '0;
    logic [4:0]  req_tag = '0;
    logic        kill = 1'b0;
    logic        div_result_val;
    logic [63:0] div_result_bits;
    logic [4:0]  div_result_tag;

    typedef struct {
        logic [63:0] bits;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    riscv_proc_divider #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
        .req_fn(req_fn), .req_dw(req_dw), .req_in0(req_in0), .req_in1(req_in1),
        .req_tag(req_tag), .kill(kill), .div_result_val(div_result_val),
        .div_result_bits(div_result_bits), .div_result_tag(div_result_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset && div_result_val) begin
            if (sb.size() == 0) begin
                check("unexpected_result_pulse", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_bits", div_result_bits, e.bits);
                check("result_tag", 64'(div_result_tag), 64'(e.tag));
                check("result_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Accept edge ends cycle 0; after it cyc marks cycle 1, so the pulse is at cyc+66.
    task automatic issue(input logic [1:0] fn, input logic dw, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag,
                         input logic [63:0] exp, input bit expect_res, input bit hold);
        exp_t e;
        @(negedge clk);
        check("req_rdy_idle", 64'(req_rdy), 64'd1);
        req_val = 1'b1; req_fn = fn; req_dw = dw;
        req_in0 = a; req_in1 = b; req_tag = tag;
        @(posedge clk); #1;
        if (!hold) req_val = 1'b0;
        if (expect_res) begin
            e.bits = exp; e.tag = tag; e.cyc = cyc + 66;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 64'(req_rdy), 64'd1);
        check("reset_val", 64'(div_result_val), 64'd0);
        check("reset_bits", div_result_bits, 64'd0);
        check("reset_tag", 64'(div_result_tag), 64'd0);
        @(negedge clk); reset = 1'b1;

        // DIVU 100/7 with explicit ready timing around the result
        issue(2'd1, 1'b1, 64'd100, 64'd7, 5'd3, 64'd14, 1'b1, 1'b0);
        repeat (32) @(posedge clk);
        #1 check("rdy_busy", 64'(req_rdy), 64'd0);
        repeat (34) @(posedge clk);
        #1 check("rdy_cycle67", 64'(req_rdy), 64'd0);
        @(posedge clk); #1;
        check("rdy_cycle68", 64'(req_rdy), 64'd1);
        wait_drain();

        issue(2'd3, 1'b1, 64'd100, 64'd7, 5'd4, 64'd2, 1'b1, 1'b0); wait_drain();
        issue(2'd0, 1'b1, -64'sd7, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0); wait_drain();
        issue(2'd2, 1'b1, -64'sd7, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0); wait_drain();
        issue(2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7,
              64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0); wait_drain();
        issue(2'd1, 1'b0, 64'hFFFF_FFFF_0000_0010, 64'd3, 5'd8, 64'd5, 1'b1, 1'b0); wait_drain();
        issue(2'd1, 1'b1, 64'd5, 64'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0); wait_drain();
        issue(2'd2, 1'b1, -64'sd5, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0); wait_drain();
        issue(2'd3, 1'b0, 64'h1_FFFF_FFFF, 64'd0, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0); wait_drain();
        issue(2'd0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
              64'h8000_0000_0000_0000, 1'b1, 1'b0); wait_drain();
        issue(2'd2, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13,
              64'd0, 1'b1, 1'b0); wait_drain();

        // kill in cycle 30, new request accepted at the end of cycle 31
        issue(2'd1, 1'b1, 64'd50, 64'd5, 5'd14, 64'd0, 1'b0, 1'b0);
        repeat (29) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        check("rdy_after_kill", 64'(req_rdy), 64'd1);
        issue(2'd1, 1'b1, 64'd81, 64'd9, 5'd15, 64'd9, 1'b1, 1'b0); wait_drain();

        // kill in cycle 67 suppresses the pulse
        issue(2'd1, 1'b1, 64'd60, 64'd6, 5'd16, 64'd0, 1'b0, 1'b0);
        repeat (66) @(posedge clk);
        #1 kill = 1'b1;
        #1 check("kill_done_val", 64'(div_result_val), 64'd0);
        @(posedge clk); #1 kill = 1'b0;
        check("rdy_after_kill67", 64'(req_rdy), 64'd1);

        // req_val held during BUSY gives a single result
        issue(2'd1, 1'b1, 64'd1000, 64'd10, 5'd17, 64'd100, 1'b1, 1'b1);
        repeat (40) @(posedge clk);
        #1 req_val = 1'b0;
        wait_drain();
        repeat (80) @(posedge clk);

        // asynchronous reset in cycle 40 drops the operation
        issue(2'd1, 1'b1, 64'd77, 64'd7, 5'd18, 64'd0, 1'b0, 1'b0);
        repeat (39) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midreset_rdy", 64'(req_rdy), 64'd1);
        check("midreset_val", 64'(div_result_val), 64'd0);
        check("midreset_bits", div_result_bits, 64'd0);
        check("midreset_tag", 64'(div_result_tag), 64'd0);
        @(negedge clk); reset = 1'b1;
        repeat (80) @(posedge clk);
        check("queue_empty_end", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
